// File: rtl/pipeline_pkg.sv
// Shared decode definitions: opcodes, register-index width, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Control bits carried through ID/EX; all-zero is a bubble.
  typedef struct packed {
    logic alu_src;
    logic reg_dst;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  // Main control decode by opcode; unknown opcodes decode as a NOP.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, $0 hardwired to zero, write-before-read bypass.
// Latency: reads combinational; writes land on the clk edge.
// Backpressure: none; a write is accepted every cycle.
import pipeline_pkg::*;

module reg_file #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  // Clear all entries on reset, otherwise commit the write-back value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // $0 reads zero; a same-cycle write to the read index forwards wdata.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (raddr1 == '0)                rdata1 = '0;
    else if (wr_en && waddr == raddr1) rdata1 = wdata;
    if (raddr2 == '0)                rdata2 = '0;
    else if (wr_en && waddr == raddr2) rdata2 = wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode, register read, load-use hazard detect and ID/EX register.
// Latency: one cycle from instruction to ID/EX outputs.
// Backpressure: stall holds IF for one cycle behind a load; ZERO_EXT_LOGIC_EN zero-extends andi/ori.
import pipeline_pkg::*;

module decode_stage #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic [31:0]          instruction,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 stall,
  output logic                 valid_out,
  output logic                 alu_src,
  output logic [5:0]           alu_op,
  output logic                 reg_dst,
  output logic [DATA_W-1:0]    data1,
  output logic [DATA_W-1:0]    data2,
  output logic [DATA_W-1:0]    sign_extend,
  output logic [REG_IDX_W-1:0] reg1,
  output logic [REG_IDX_W-1:0] reg2,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 mem_to_reg
);

  logic [5:0]           op;
  logic [REG_IDX_W-1:0] rs, rt, rd;
  logic [15:0]          imm;
  logic [DATA_W-1:0]    rd_data1, rd_data2;
  logic [DATA_W-1:0]    ext_imm;
  ctrl_t                ctrl;
  logic                 uses_rt;
  logic                 bubble;

  assign op  = instruction[31:26];
  assign rs  = instruction[25:21];
  assign rt  = instruction[20:16];
  assign rd  = instruction[15:11];
  assign imm = instruction[15:0];

  reg_file #(.NREGS(NREGS), .DATA_W(DATA_W)) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_reg),
    .wdata  (wb_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rd_data1),
    .rdata2 (rd_data2)
  );

  assign ctrl = decode_ctrl(op);

  // Immediate extension; logical immediates optionally zero-extend.
  always_comb begin
    ext_imm = {{(DATA_W-16){imm[15]}}, imm};
`ifdef ZERO_EXT_LOGIC_EN
    if (op == OP_ANDI || op == OP_ORI) ext_imm = {{(DATA_W-16){1'b0}}, imm};
`endif
  end

  // rt is only a source operand for R-type and stores.
  assign uses_rt = (op == OP_RTYPE) || (op == OP_SW);

  // Load-use hazard against the load in ID/EX; held low in reset.
  assign stall = rst && if_valid && !flush &&
                 valid_out && mem_read && (reg1 != '0) &&
                 ((reg1 == rs) || ((reg1 == rt) && uses_rt));

  assign bubble = stall || flush || !if_valid;

  // ID/EX pipeline register: controls zeroed for a bubble, datapath always loaded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_out   <= 1'b0;
      alu_src     <= 1'b0;
      alu_op      <= '0;
      reg_dst     <= 1'b0;
      data1       <= '0;
      data2       <= '0;
      sign_extend <= '0;
      reg1        <= '0;
      reg2        <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      reg_write   <= 1'b0;
      mem_to_reg  <= 1'b0;
    end else begin
      alu_op      <= op;
      data1       <= rd_data1;
      data2       <= rd_data2;
      sign_extend <= ext_imm;
      reg1        <= rt;
      reg2        <= rd;
      if (bubble) begin
        valid_out  <= 1'b0;
        alu_src    <= 1'b0;
        reg_dst    <= 1'b0;
        mem_read   <= 1'b0;
        mem_write  <= 1'b0;
        reg_write  <= 1'b0;
        mem_to_reg <= 1'b0;
      end else begin
        valid_out  <= 1'b1;
        alu_src    <= ctrl.alu_src;
        reg_dst    <= ctrl.reg_dst;
        mem_read   <= ctrl.mem_read;
        mem_write  <= ctrl.mem_write;
        reg_write  <= ctrl.reg_write;
        mem_to_reg <= ctrl.mem_to_reg;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, register file, bypass, hazards, immediates.
// Latency: checks one edge after each instruction is presented.
// Backpressure: stall is checked combinationally before the edge it affects.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] instruction;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        stall;
  logic        valid_out;
  logic        alu_src;
  logic [5:0]  alu_op;
  logic        reg_dst;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] sign_extend;
  logic [4:0]  reg1;
  logic [4:0]  reg2;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;

  int tests = 0;
  int fails = 0;

  decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .instruction (instruction),
    .flush       (flush),
    .wb_we       (wb_we),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .stall       (stall),
    .valid_out   (valid_out),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .reg_dst     (reg_dst),
    .data1       (data1),
    .data2       (data2),
    .sign_extend (sign_extend),
    .reg1        (reg1),
    .reg2        (reg2),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    if_valid    = 1'b1;
    instruction = ins;
    flush       = 1'b0;
  endtask

  initial begin
    rst = 1'b0; if_valid = 1'b0; instruction = 32'h0; flush = 1'b0;
    wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'h0;

    // Reset held for two edges
    tick(); tick();
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_data1", data1, 32'h0);
    chk("rst_sext", sign_extend, 32'h0);
    chk("rst_alu_op", {26'b0, alu_op}, 32'h0);
    chk("rst_ctrl", {26'b0, alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg}, 32'h0);
    chk("rst_regs", {22'b0, reg1, reg2}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);

    // Release; add $3,$5,$0 reads a cleared register
    rst = 1'b1;
    issue(32'h00A01820);
    tick();
    chk("post_rst_data1", data1, 32'h0);
    chk("post_rst_valid", {31'b0, valid_out}, 32'h1);

    // Write $5 then read it back
    if_valid = 1'b0; wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'h00001234;
    tick();
    chk("idle_bubble", {31'b0, valid_out}, 32'h0);
    wb_we = 1'b0;
    issue(32'h00A01820);
    tick();
    chk("wr_data1", data1, 32'h00001234);
    chk("wr_data2", data2, 32'h0);
    chk("wr_reg_dst", {31'b0, reg_dst}, 32'h1);
    chk("wr_reg2", {27'b0, reg2}, 32'd3);
    chk("wr_alu_src", {31'b0, alu_src}, 32'h0);
    chk("wr_sext", sign_extend, 32'h00001820);
    chk("wr_reg_write", {31'b0, reg_write}, 32'h1);

    // Same-cycle bypass, then the stored value
    wb_we = 1'b1; wb_reg = 5'd7; wb_data = 32'hDEADBEEF;
    issue(32'h00E00020);
    tick();
    chk("bypass_data1", data1, 32'hDEADBEEF);
    wb_we = 1'b0;
    tick();
    chk("stored_data1", data1, 32'hDEADBEEF);

    // $0 write ignored, same cycle and after
    wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFFFFFF;
    issue(32'h00000020);
    tick();
    chk("zero_bypass", data1, 32'h0);
    wb_we = 1'b0;
    tick();
    chk("zero_data1", data1, 32'h0);
    chk("zero_data2", data2, 32'h0);

    // Load-use: lw $8,4($9) then add $10,$8,$8
    issue(32'h8D280004);
    tick();
    chk("lw_ctrl", {26'b0, alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg}, 32'h2B);
    chk("lw_reg1", {27'b0, reg1}, 32'd8);
    chk("lw_sext", sign_extend, 32'h4);
    chk("lw_alu_op", {26'b0, alu_op}, 32'h23);
    issue(32'h01085020);
    #1;
    chk("lu_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("lu_bubble_valid", {31'b0, valid_out}, 32'h0);
    chk("lu_bubble_rw", {31'b0, reg_write}, 32'h0);
    chk("lu_bubble_mr", {31'b0, mem_read}, 32'h0);
    chk("lu_stall_drop", {31'b0, stall}, 32'h0);
    tick();
    chk("lu_add_valid", {31'b0, valid_out}, 32'h1);
    chk("lu_add_reg2", {27'b0, reg2}, 32'd10);
    chk("lu_add_rw", {31'b0, reg_write}, 32'h1);

    // Load-use with flush: no stall, bubble inserted
    issue(32'h8D280004);
    tick();
    issue(32'h01085020);
    flush = 1'b1;
    #1;
    chk("fl_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("fl_valid", {31'b0, valid_out}, 32'h0);
    chk("fl_rw", {31'b0, reg_write}, 32'h0);
    flush = 1'b0;

    // rt match only stalls for R-type/sw consumers
    issue(32'h8D280004);
    tick();
    issue(32'h20280001);
    #1;
    chk("addi_rt_nostall", {31'b0, stall}, 32'h0);
    issue(32'hAC280000);
    #1;
    chk("sw_rt_stall", {31'b0, stall}, 32'h1);

    // Reset during a stall drops it immediately
    rst = 1'b0;
    #1;
    chk("rst_stall_drop", {31'b0, stall}, 32'h0);
    tick();
    chk("rst_stall_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_stall_mr", {31'b0, mem_read}, 32'h0);
    rst = 1'b1;

    // Immediates
    issue(32'h2022FFFF);
    tick();
    chk("addi_sext", sign_extend, 32'hFFFFFFFF);
    chk("addi_alu_src", {31'b0, alu_src}, 32'h1);
    chk("addi_reg_dst", {31'b0, reg_dst}, 32'h0);
    issue(32'h3422FFFF);
    tick();
`ifdef ZERO_EXT_LOGIC_EN
    chk("ori_ext", sign_extend, 32'h0000FFFF);
`else
    chk("ori_ext", sign_extend, 32'hFFFFFFFF);
`endif
    chk("ori_ctrl", {26'b0, alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg}, 32'h22);

    // Unknown opcode issues as a NOP
    issue(32'hFC000000);
    tick();
    chk("nop_valid", {31'b0, valid_out}, 32'h1);
    chk("nop_ctrl", {26'b0, alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage and ID/EX pipeline register. It is the producer side of the execute-stage interface.
- Decodes a 32-bit MIPS instruction and reads a 32x32 register file with a write-back port.
- Registers the operands and controls that the execute stage consumes: alu_src, alu_op, reg_dst, data1, data2, sign_extend, reg1, reg2.
- Detects load-use hazards against the instruction currently held in ID/EX and inserts bubbles.

Parameters:
- NREGS, 32, register file depth. Fixed at 32; the parameter exists only for documentation.
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low. rst=0 at a rising clk edge resets the block.
- if_valid  in  1  instruction is valid this cycle.
- instruction  in  32  instruction word from IF.
- flush  in  1  discard the instruction in decode (taken branch or jump).
- wb_we  in  1  write-back enable.
- wb_reg  in  5  write-back destination register.
- wb_data  in  32  write-back data.
- stall  out  1  combinational; IF must hold PC and instruction while stall=1.
- valid_out  out  1  ID/EX slot holds a real instruction.
- alu_src  out  1  1 selects sign_extend as ALU operand B.
- alu_op  out  6  opcode, instruction[31:26].
- reg_dst  out  1  1 selects reg2 (rd) as destination.
- data1  out  32  value of rs.
- data2  out  32  value of rt.
- sign_extend  out  32  extended immediate, instruction[15:0].
- reg1  out  5  rt, instruction[20:16].
- reg2  out  5  rd, instruction[15:11].
- mem_read  out  1  load.
- mem_write  out  1  store.
- reg_write  out  1  writes a register.
- mem_to_reg  out  1  write-back data comes from memory.

Behaviour:
- Reset: rst=0 at a clk edge clears every registered output to 0 and every register-file entry to 0. stall evaluates to 0 after reset.
- Latency: one cycle. Decode results for the instruction present at edge N appear on the outputs after edge N.
- Register file writes:
  - Write on the clk edge when wb_we=1 and wb_reg!=0.
  - Register $0 always reads 0; writes to it are ignored.
- Register file reads are combinational with internal bypass. If wb_we=1, wb_reg!=0 and wb_reg equals rs (or rt), that read returns wb_data in the same cycle.
- Control decode by opcode:
  - 0x00 R-type: reg_dst=1, reg_write=1.
  - 0x08 addi, 0x0A slti, 0x0C andi, 0x0D ori: alu_src=1, reg_write=1.
  - 0x23 lw: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
  - 0x2B sw: alu_src=1, mem_write=1.
  - Any other opcode: all controls 0, valid_out=1 (a NOP).
- Immediate extension: sign_extend = {{16{imm[15]}}, imm}. R-type instructions also extend the funct field this way; the execute stage uses sign_extend[3:0].
- Load-use hazard, combinational. stall=1 when all of the following hold:
  - if_valid=1 and flush=0;
  - the ID/EX slot holds a load (valid_out=1, mem_read=1) and reg1!=0;
  - reg1 equals rs, or reg1 equals rt and the decoding instruction is R-type or sw.
- Bubble: loaded into ID/EX when stall=1, flush=1 or if_valid=0.
  - valid_out, mem_read, mem_write, reg_write, mem_to_reg, alu_src and reg_dst are 0.
  - Datapath fields may hold any value.
- Flush has priority over stall. A stall lasts exactly one cycle per load, because the following bubble clears mem_read.
- Reset asserted during a stall: reset wins and stall drops the same cycle.

Optional Feature:
- Macro: ZERO_EXT_LOGIC_EN.
- Defined: andi (0x0C) and ori (0x0D) zero-extend, giving sign_extend = {16'h0, imm}.
- Undefined: all immediates are sign-extended.

Decomposition:
- Package pipeline_pkg holds the opcode constants (OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW) and the register-index width.
- Sub-module reg_file holds the 32x32 array, the $0 hardwiring, reset clear and write-before-read bypass.
- Decode, hazard detection and the ID/EX register stay in decode_stage.

Test Plan:
- Reset: hold rst=0 for 2 edges -> all outputs 0. After release, decode add $3,$5,$0 -> data1=0.
- Write then read: write wb $5=0x00001234, then instruction 0x00A01820 (add $3,$5,$0) -> data1=0x00001234, reg_dst=1, reg2=3, alu_src=0, sign_extend=0x00001820, reg_write=1.
- Same-cycle bypass: wb $7=0xDEADBEEF in the same cycle as 0x00E00020 (add $0,$7,$0) -> data1=0xDEADBEEF.
- $0 protection: wb_reg=0, wb_data=0xFFFFFFFF, then read $0 -> data1=0.
- Load-use:
  - Issue 0x8D280004 (lw $8,4($9)), then 0x01085020 (add $10,$8,$8).
  - Required: stall=1 for one cycle, then a bubble (valid_out=0, reg_write=0), then the add issues with reg2=10.
  - Repeat with flush=1 during the add -> stall=0 and a bubble is inserted.
- Immediates:
  - 0x2022FFFF (addi $2,$1,-1) -> sign_extend=0xFFFFFFFF, alu_src=1.
  - 0x3422FFFF (ori) -> 0x0000FFFF with ZERO_EXT_LOGIC_EN, 0xFFFFFFFF without.
